// File: rtl/udp_rx_noc_out_pkg.sv
// Shared UDP-tile definitions: NoC flit layouts, message types and length helpers
// used by the UDP receive-to-NoC output stage.
package udp_rx_noc_out_pkg;

  localparam int IP_ADDR_W       = 32;
  localparam int XY_WIDTH        = 8;
  localparam int NOC_FBITS_WIDTH = 4;
  localparam int MAC_INTERFACE_W = 512;
  localparam int MAC_PADBYTES_W  = 6;
  localparam int NOC_DATA_WIDTH  = 512;
  localparam int NOC_DATA_BYTES  = NOC_DATA_WIDTH / 8;
  localparam int UDP_HDR_BYTES   = 8;
  localparam int MSG_LEN_W       = 22;
  localparam int FLIT_CNT_W      = 17;
  localparam int PKT_ID_W        = 32;
  localparam int TIMESTAMP_W     = 64;

  typedef enum logic [7:0] {
    UDP_RX_SEGMENT = 8'd14,
    UDP_TX_SEGMENT = 8'd15
  } msg_type_e;

  typedef enum logic [1:0] {
    READY      = 2'd0,
    HDR_FLIT   = 2'd1,
    META_FLIT  = 2'd2,
    DATA_FLITS = 2'd3
  } noc_out_state_e;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] chksum;
  } udp_pkt_hdr;

  typedef struct packed {
    logic [PKT_ID_W-1:0]    packet_id;
    logic [TIMESTAMP_W-1:0] timestamp;
  } tracker_stats_struct;

  localparam int HDR_USED_W = 4 * XY_WIDTH + 2 * NOC_FBITS_WIDTH + MSG_LEN_W + 8
                              + PKT_ID_W + TIMESTAMP_W;
  localparam int HDR_PAD_W  = NOC_DATA_WIDTH - HDR_USED_W;

  typedef struct packed {
    logic [XY_WIDTH-1:0]        dst_x;
    logic [XY_WIDTH-1:0]        dst_y;
    logic [NOC_FBITS_WIDTH-1:0] dst_fbits;
    logic [MSG_LEN_W-1:0]       msg_len;
    msg_type_e                  msg_type;
    logic [XY_WIDTH-1:0]        src_x;
    logic [XY_WIDTH-1:0]        src_y;
    logic [NOC_FBITS_WIDTH-1:0] src_fbits;
    tracker_stats_struct        stats;
    logic [HDR_PAD_W-1:0]       padding;
  } noc_hdr_flit;

  localparam int META_PAD_W = NOC_DATA_WIDTH - 2 * IP_ADDR_W - 48;

  typedef struct packed {
    logic [IP_ADDR_W-1:0]  src_ip;
    logic [IP_ADDR_W-1:0]  dst_ip;
    logic [15:0]           src_port;
    logic [15:0]           dst_port;
    logic [15:0]           data_length;
    logic [META_PAD_W-1:0] padding;
  } udp_rx_metadata_flit;

  // Payload bytes after the UDP header; malformed short lengths count as empty.
  function automatic logic [15:0] calc_data_len(input logic [15:0] udp_len);
    return (udp_len < 16'(UDP_HDR_BYTES)) ? 16'd0 : udp_len - 16'(UDP_HDR_BYTES);
  endfunction

  function automatic logic [FLIT_CNT_W-1:0] calc_flit_cnt(input logic [15:0] data_len);
    logic [FLIT_CNT_W-1:0] w_sum;
    w_sum = {1'b0, data_len} + FLIT_CNT_W'(NOC_DATA_BYTES - 1);
    return w_sum >> $clog2(NOC_DATA_BYTES);
  endfunction

endpackage

// File: rtl/udp_rx_noc_out_if.sv
// Bundle/data/NoC handshake signals of the UDP receive-to-NoC output stage.
// slave is the stage itself; master is whatever drives it and sinks its flits.
interface udp_rx_noc_out_if;
  import udp_rx_noc_out_pkg::*;

  logic                       udp_rx_out_hdr_val;
  logic [IP_ADDR_W-1:0]       udp_rx_out_src_ip_addr;
  logic [IP_ADDR_W-1:0]       udp_rx_out_dst_ip_addr;
  udp_pkt_hdr                 udp_rx_out_udp_hdr;
  tracker_stats_struct        udp_rx_out_timestamp;
  logic [XY_WIDTH-1:0]        udp_rx_out_dst_x;
  logic [XY_WIDTH-1:0]        udp_rx_out_dst_y;
  logic [NOC_FBITS_WIDTH-1:0] udp_rx_out_dst_fbits;
  logic                       udp_rx_out_hdr_rdy;

  logic                       udp_rx_out_data_val;
  logic [MAC_INTERFACE_W-1:0] udp_rx_out_data;
  logic                       udp_rx_out_data_last;
  logic [MAC_PADBYTES_W-1:0]  udp_rx_out_data_padbytes;
  logic                       udp_rx_out_data_rdy;

  logic                       noc0_vrtoc_udp_rx_out_val;
  logic [NOC_DATA_WIDTH-1:0]  noc0_vrtoc_udp_rx_out_data;
  logic                       noc0_vrtoc_udp_rx_out_rdy;

  modport slave (
    input  udp_rx_out_hdr_val, udp_rx_out_src_ip_addr, udp_rx_out_dst_ip_addr,
           udp_rx_out_udp_hdr, udp_rx_out_timestamp, udp_rx_out_dst_x,
           udp_rx_out_dst_y, udp_rx_out_dst_fbits,
           udp_rx_out_data_val, udp_rx_out_data, udp_rx_out_data_last,
           udp_rx_out_data_padbytes, noc0_vrtoc_udp_rx_out_rdy,
    output udp_rx_out_hdr_rdy, udp_rx_out_data_rdy,
           noc0_vrtoc_udp_rx_out_val, noc0_vrtoc_udp_rx_out_data
  );

  modport master (
    output udp_rx_out_hdr_val, udp_rx_out_src_ip_addr, udp_rx_out_dst_ip_addr,
           udp_rx_out_udp_hdr, udp_rx_out_timestamp, udp_rx_out_dst_x,
           udp_rx_out_dst_y, udp_rx_out_dst_fbits,
           udp_rx_out_data_val, udp_rx_out_data, udp_rx_out_data_last,
           udp_rx_out_data_padbytes, noc0_vrtoc_udp_rx_out_rdy,
    input  udp_rx_out_hdr_rdy, udp_rx_out_data_rdy,
           noc0_vrtoc_udp_rx_out_val, noc0_vrtoc_udp_rx_out_data
  );

endinterface

// File: rtl/udp_rx_noc_out_datap.sv
// Datapath: captures the packet bundle, formats header/metadata flits, selects the
// outgoing NoC word and tracks how many payload flits are still owed.
module udp_rx_noc_out_datap
  import udp_rx_noc_out_pkg::*;
#(
  parameter logic [XY_WIDTH-1:0] SRC_X = '0,
  parameter logic [XY_WIDTH-1:0] SRC_Y = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic                       i_beat,
  input  noc_out_state_e             i_state,
  input  logic [IP_ADDR_W-1:0]       i_src_ip,
  input  logic [IP_ADDR_W-1:0]       i_dst_ip,
  input  udp_pkt_hdr                 i_udp_hdr,
  input  tracker_stats_struct        i_stats,
  input  logic [XY_WIDTH-1:0]        i_dst_x,
  input  logic [XY_WIDTH-1:0]        i_dst_y,
  input  logic [NOC_FBITS_WIDTH-1:0] i_dst_fbits,
  input  logic [MAC_INTERFACE_W-1:0] i_data,
  output logic [NOC_DATA_WIDTH-1:0]  o_noc_data,
  output logic                       o_has_data,
  output logic                       o_last_beat
);

  logic [IP_ADDR_W-1:0]       r_src_ip;
  logic [IP_ADDR_W-1:0]       r_dst_ip;
  udp_pkt_hdr                 r_udp_hdr;
  tracker_stats_struct        r_stats;
  logic [XY_WIDTH-1:0]        r_dst_x;
  logic [XY_WIDTH-1:0]        r_dst_y;
  logic [NOC_FBITS_WIDTH-1:0] r_dst_fbits;
  logic [FLIT_CNT_W-1:0]      r_flits_remaining;

  logic [15:0]               w_data_len;
  logic [FLIT_CNT_W-1:0]     w_flit_cnt;
  noc_hdr_flit               w_hdr_flit;
  udp_rx_metadata_flit       w_meta_flit;
  logic                      w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ip          <= '0;
      r_dst_ip          <= '0;
      r_udp_hdr         <= '0;
      r_stats           <= '0;
      r_dst_x           <= '0;
      r_dst_y           <= '0;
      r_dst_fbits       <= '0;
      r_flits_remaining <= '0;
    end else if (i_load) begin
      r_src_ip          <= i_src_ip;
      r_dst_ip          <= i_dst_ip;
      r_udp_hdr         <= i_udp_hdr;
      r_stats           <= i_stats;
      r_dst_x           <= i_dst_x;
      r_dst_y           <= i_dst_y;
      r_dst_fbits       <= i_dst_fbits;
      r_flits_remaining <= calc_flit_cnt(calc_data_len(i_udp_hdr.length));
    end else if (i_beat) begin
      r_flits_remaining <= r_flits_remaining - FLIT_CNT_W'(1);
    end
  end

  assign w_data_len = calc_data_len(r_udp_hdr.length);
  assign w_flit_cnt = calc_flit_cnt(w_data_len);

  always_comb begin
    w_hdr_flit           = '0;
    w_hdr_flit.dst_x     = r_dst_x;
    w_hdr_flit.dst_y     = r_dst_y;
    w_hdr_flit.dst_fbits = r_dst_fbits;
    w_hdr_flit.msg_len   = MSG_LEN_W'(w_flit_cnt) + MSG_LEN_W'(1);
    w_hdr_flit.msg_type  = UDP_RX_SEGMENT;
    w_hdr_flit.src_x     = SRC_X;
    w_hdr_flit.src_y     = SRC_Y;
    w_hdr_flit.stats     = r_stats;
  end

  always_comb begin
    w_meta_flit             = '0;
    w_meta_flit.src_ip      = r_src_ip;
    w_meta_flit.dst_ip      = r_dst_ip;
    w_meta_flit.src_port    = r_udp_hdr.src_port;
    w_meta_flit.dst_port    = r_udp_hdr.dst_port;
    w_meta_flit.data_length = w_data_len;
  end

  // Outside the flit-emitting states the bus is parked at zero.
  always_comb begin
    o_noc_data = '0;
    case (i_state)
      HDR_FLIT:   o_noc_data = w_hdr_flit;
      META_FLIT:  o_noc_data = w_meta_flit;
      DATA_FLITS: o_noc_data = i_data;
      default:    o_noc_data = '0;
    endcase
  end

  assign o_has_data  = (r_flits_remaining != '0);
  assign o_last_beat = (r_flits_remaining == FLIT_CNT_W'(1));

  assign w_unused = ^r_udp_hdr.chksum;

endmodule

// File: rtl/udp_rx_noc_out.sv
// UDP receive-to-NoC output stage: turns a parsed packet bundle plus payload beats
// into a header flit, a metadata flit and ceil(len/NOC_DATA_BYTES) data flits.
module udp_rx_noc_out
  import udp_rx_noc_out_pkg::*;
#(
  parameter logic [XY_WIDTH-1:0] SRC_X = '0,
  parameter logic [XY_WIDTH-1:0] SRC_Y = '0
) (
  input logic             clk,
  input logic             rst_n,
  udp_rx_noc_out_if.slave bus
);

  noc_out_state_e r_state;
  logic           r_hdr_rdy;
  logic           r_flit_val;
  logic           r_in_data;

  logic w_load;
  logic w_beat;
  logic w_has_data;
  logic w_last_beat;
  logic w_noc_rdy;
  logic w_unused;

  assign w_noc_rdy = bus.noc0_vrtoc_udp_rx_out_rdy;
  assign w_load    = (r_state == READY) && bus.udp_rx_out_hdr_val;
  assign w_beat    = r_in_data && bus.udp_rx_out_data_val && w_noc_rdy;

  // Framing is owned by the flit counter; data_last and padbytes are not consulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= READY;
      r_hdr_rdy  <= 1'b1;
      r_flit_val <= 1'b0;
      r_in_data  <= 1'b0;
    end else begin
      case (r_state)
        READY: begin
          if (bus.udp_rx_out_hdr_val) begin
            r_state    <= HDR_FLIT;
            r_hdr_rdy  <= 1'b0;
            r_flit_val <= 1'b1;
          end
        end
        HDR_FLIT: begin
          if (w_noc_rdy) r_state <= META_FLIT;
        end
        META_FLIT: begin
          if (w_noc_rdy) begin
            r_flit_val <= 1'b0;
            if (w_has_data) begin
              r_state   <= DATA_FLITS;
              r_in_data <= 1'b1;
            end else begin
              r_state   <= READY;
              r_hdr_rdy <= 1'b1;
            end
          end
        end
        DATA_FLITS: begin
          if (w_beat && w_last_beat) begin
            r_state   <= READY;
            r_in_data <= 1'b0;
            r_hdr_rdy <= 1'b1;
          end
        end
        default: begin
          r_state    <= READY;
          r_hdr_rdy  <= 1'b1;
          r_flit_val <= 1'b0;
          r_in_data  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.udp_rx_out_hdr_rdy        = r_hdr_rdy;
  assign bus.udp_rx_out_data_rdy       = r_in_data && w_noc_rdy;
  assign bus.noc0_vrtoc_udp_rx_out_val = r_in_data ? bus.udp_rx_out_data_val : r_flit_val;

  udp_rx_noc_out_datap #(
    .SRC_X (SRC_X),
    .SRC_Y (SRC_Y)
  ) u_datap (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_beat      (w_beat),
    .i_state     (r_state),
    .i_src_ip    (bus.udp_rx_out_src_ip_addr),
    .i_dst_ip    (bus.udp_rx_out_dst_ip_addr),
    .i_udp_hdr   (bus.udp_rx_out_udp_hdr),
    .i_stats     (bus.udp_rx_out_timestamp),
    .i_dst_x     (bus.udp_rx_out_dst_x),
    .i_dst_y     (bus.udp_rx_out_dst_y),
    .i_dst_fbits (bus.udp_rx_out_dst_fbits),
    .i_data      (bus.udp_rx_out_data),
    .o_noc_data  (bus.noc0_vrtoc_udp_rx_out_data),
    .o_has_data  (w_has_data),
    .o_last_beat (w_last_beat)
  );

  assign w_unused = ^{bus.udp_rx_out_data_last, bus.udp_rx_out_data_padbytes};

endmodule

// File: doc/udp_rx_noc_out.md
UDP_RX_NOC_OUT -- requirements
Module: udp_rx_noc_out

Interface
REQ-001 SHALL have parameter SRC_X, default 0: NoC X coordinate of this tile, placed in the header flit.
REQ-002 SHALL have parameter SRC_Y, default 0: NoC Y coordinate of this tile, placed in the header flit.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 udp_rx_out_hdr_val  in  1  header/meta bundle valid.
REQ-007 udp_rx_out_src_ip_addr, udp_rx_out_dst_ip_addr  in  IP_ADDR_W  packet IPs.
REQ-008 udp_rx_out_udp_hdr  in  udp_pkt_hdr  parsed UDP header.
REQ-009 udp_rx_out_timestamp  in  tracker_stats_struct  packet_id/timestamp.
REQ-010 udp_rx_out_dst_x, udp_rx_out_dst_y, udp_rx_out_dst_fbits  in  XY_WIDTH, XY_WIDTH, NOC_FBITS_WIDTH  destination of this packet.
REQ-011 udp_rx_out_hdr_rdy  out  1  bundle accepted.
REQ-012 udp_rx_out_data_val  in  1; udp_rx_out_data  in  MAC_INTERFACE_W; udp_rx_out_data_last  in  1; udp_rx_out_data_padbytes  in  MAC_PADBYTES_W; udp_rx_out_data_rdy  out  1.
REQ-013 noc0_vrtoc_udp_rx_out_val  out  1; noc0_vrtoc_udp_rx_out_data  out  NOC_DATA_WIDTH; noc0_vrtoc_udp_rx_out_rdy  in  1.

Function
REQ-014 SHALL implement FSM states READY, HDR_FLIT, META_FLIT, DATA_FLITS.
REQ-015 READY: hdr_rdy=1; on hdr_val, SHALL register all bundle fields and go to HDR_FLIT.
REQ-016 data_length SHALL be udp_hdr.length - UDP_HDR_BYTES, forced to 0 when length < UDP_HDR_BYTES.
REQ-017 Data flit count SHALL be ceil(data_length / NOC_DATA_BYTES), computed in 17 bits without overflow.
REQ-018 Header flit msg_len SHALL be 1 + data flit count; msg_type UDP_RX_SEGMENT; src = SRC_X/SRC_Y; dst = registered dst fields; packet_id/timestamp copied.
REQ-019 HDR_FLIT: noc val=1 with the header flit; on noc rdy, go to META_FLIT.
REQ-020 META_FLIT: noc val=1 with udp_rx_metadata_flit {src_ip, dst_ip, src_port, dst_port, data_length}; on noc rdy, go to DATA_FLITS if data flit count>0, else READY.
REQ-021 DATA_FLITS: noc val = data_val; data_rdy = noc rdy; noc data = udp_rx_out_data; no other combinational path.
REQ-022 Each accepted beat SHALL decrement flits_remaining; the beat at flits_remaining==1 is last, and the FSM returns to READY.
REQ-023 The counter SHALL govern framing; data_last/padbytes SHALL NOT alter flit count.
REQ-024 hdr_rdy SHALL be 0 and data_rdy SHALL be 0 outside READY and DATA_FLITS, respectively.
REQ-025 noc data SHALL hold steady while val=1 and rdy=0.
REQ-026 Latency: header flit valid 1 cycle after bundle acceptance; back-to-back packets SHALL incur exactly one READY cycle between them.

Reset
REQ-027 On rst_n=0, FSM SHALL enter READY and registered fields/counter SHALL clear to 0, asynchronously.
REQ-028 Reset outputs: hdr_rdy=1, data_rdy=0, noc val=0, noc data=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no partial flit SHALL appear after release.

Structure
REQ-030 udp_rx_metadata_flit, the UDP_RX_SEGMENT msg type, and UDP_HDR_BYTES SHALL reside in the shared udp tile package/defs.
REQ-031 SHALL split into FSM control plus sub-module udp_rx_noc_out_datap (registers, flit formatting, counter).

Verification (NOC_DATA_BYTES=64)
REQ-032 udp length=8 -> header msg_len=1, meta data_length=0, then READY; no data_rdy pulse.
REQ-033 udp length=72 (64B) -> msg_len=2, one data flit, data_rdy only during DATA_FLITS.
REQ-034 udp length=137 (129B) -> msg_len=4; 3 data flits; returns to READY after 3rd beat regardless of data_last.
REQ-035 noc rdy toggling 1/0 per cycle during 129B packet -> every flit held stable while stalled; no loss or duplication.
REQ-036 udp length=4 (malformed) -> data_length=0, msg_len=1.
REQ-037 rst_n asserted after 1 of 3 data flits -> val=0 immediately; next packet emits a clean header flit.
